serial_byte_collector: RTL

- Downstream stage of the memory-driven serial bit generator. It consumes that stage's one-bit output stream and reassembles 8-bit bytes.
- Completed bytes are pushed into a small synchronous FIFO. A consumer drains the FIFO through a read handshake.
- Status flags are provided: byte count, full/empty, and sticky overflow/underflow.
- Together with the generator, it closes the loopback path so that transmitted memory contents (0xcc/0xaa pattern) can be checked.

---
 rtl/serial_byte_collector_pkg.sv | 20 ++
 rtl/serial_byte_collector_byte_fifo.sv | 93 +++++++++
 rtl/serial_byte_collector.sv | 68 ++++++
 3 files changed

// File: rtl/serial_byte_collector_pkg.sv
// ============================================================================
// Module   : serial_byte_collector_pkg
// Purpose  : Shared sizing constants and loopback pattern values.
// Revision : 1.0
// ============================================================================
`default_nettype none

package serial_byte_collector_pkg;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int PTR_W = 4;
    localparam int CNT_W = 3;

    localparam logic [WIDTH-1:0] C_PATTERN_CC = 8'hcc;
    localparam logic [WIDTH-1:0] C_PATTERN_AA = 8'haa;

endpackage

`default_nettype wire

// File: rtl/serial_byte_collector_byte_fifo.sv
// ============================================================================
// Module   : byte_fifo
// Purpose  : Synchronous byte FIFO with occupancy count and sticky error flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module byte_fifo
    import serial_byte_collector_pkg::*;
(
    input  logic             clk,
    input  logic             clear_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop_req,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_rd_valid,
    output logic             o_empty,
    output logic             o_full,
    output logic [PTR_W:0]   o_count,
    output logic             o_overflow,
    output logic             o_underflow
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push_ok;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
    // A pop frees a slot in the same edge, so a full FIFO still accepts a push.
    assign w_pop     = i_pop_req && !w_empty;
    assign w_push_ok = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr    <= r_rptr + 1'b1;
                r_rd_data <= r_mem[r_rptr];
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (i_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            if (i_pop_req && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

`default_nettype wire

// File: rtl/serial_byte_collector.sv
// ============================================================================
// Module   : serial_byte_collector
// Purpose  : Reassembles MSB-first serial bits into bytes and queues them.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_byte_collector
    import serial_byte_collector_pkg::*;
(
    input  logic             clk,
    input  logic             clear_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             sync,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             empty,
    output logic             full,
    output logic [PTR_W:0]   count,
    output logic             overflow,
    output logic             underflow
);

    // Only the first WIDTH-1 bits need storage; the last bit goes straight in.
    logic [WIDTH-2:0] r_shift;
    logic [CNT_W-1:0] r_bitcnt;

    logic             w_push;
    logic [WIDTH-1:0] w_byte;

    assign w_push = bit_valid && !sync && (r_bitcnt == CNT_W'(WIDTH-1));
    assign w_byte = {r_shift, bit_in};

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
        end else if (bit_valid) begin
            if (sync) begin
                r_shift  <= {{(WIDTH-2){1'b0}}, bit_in};
                r_bitcnt <= CNT_W'(1);
            end else begin
                r_shift  <= {r_shift[WIDTH-3:0], bit_in};
                r_bitcnt <= r_bitcnt + 1'b1;
            end
        end
    end

    byte_fifo u_fifo (
        .clk         (clk),
        .clear_n     (clear_n),
        .i_push      (w_push),
        .i_push_data (w_byte),
        .i_pop_req   (rd_en),
        .o_rd_data   (rd_data),
        .o_rd_valid  (rd_valid),
        .o_empty     (empty),
        .o_full      (full),
        .o_count     (count),
        .o_overflow  (overflow),
        .o_underflow (underflow)
    );

endmodule

`default_nettype wire
